// File: rtl/stream_demux_if.sv
// Handshake bundle between a packet source, the demux and its per-channel consumers.
`timescale 1ns/1ps
interface stream_demux_if #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
);
   logic [DATA_W-1:0]         in_data;
   logic [SEL_W-1:0]          in_sel;
   logic                      in_last;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_OUT*DATA_W-1:0] out_data;
   logic [NUM_OUT-1:0]        out_last;
   logic [NUM_OUT-1:0]        out_valid;
   logic [NUM_OUT-1:0]        out_ready;
   logic                      busy;
   logic [7:0]                drop_count;

   modport slave (
      input  in_data, in_sel, in_last, in_valid, out_ready,
      output in_ready, out_data, out_last, out_valid, busy, drop_count
   );

   modport master (
      output in_data, in_sel, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_last, out_valid, busy, drop_count
   );
endinterface

// File: rtl/stream_demux.sv
// 1-to-NUM_OUT packet demux: destination latched on the first beat, one registered slot per channel.
// state     | meaning
// ST_IDLE   | next accepted beat is the first beat of a packet; in_sel selects the target
// ST_LOCKED | mid-packet; target held in lock_sel_q until the last beat is accepted
`timescale 1ns/1ps
module stream_demux #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
) (
   input logic           clk,
   input logic           reset,
   stream_demux_if.slave bus
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0]  data_q [NUM_OUT];
   logic [DATA_W-1:0]  data_d [NUM_OUT];
   logic [NUM_OUT-1:0] last_q, last_d;
   logic [NUM_OUT-1:0] valid_q, valid_d;

   logic [SEL_W-1:0]   target;
   logic [NUM_OUT-1:0] load;
   logic               ready;
   logic               accept;
   logic               drop_beat;
   logic [NUM_OUT*DATA_W-1:0] out_data_c;

   assign target = (state_q == ST_LOCKED) ? lock_sel_q : bus.in_sel;

   // A target with no matching channel is the drop path and is always ready.
   always_comb begin
      ready = 1'b1;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (target == SEL_W'(k)) begin
            ready = ~valid_q[k] | bus.out_ready[k];
         end
      end
   end

   assign accept = bus.in_valid & ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         load[k] = accept & (target == SEL_W'(k));
      end
   end

   assign drop_beat = accept & ~|load;

   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (load[k]) begin
            data_d[k]  = bus.in_data;
            last_d[k]  = bus.in_last;
            valid_d[k] = 1'b1;
         end else if (valid_q[k] && bus.out_ready[k]) begin
            valid_d[k] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !bus.in_last) begin
               state_d    = ST_LOCKED;
               lock_sel_d = bus.in_sel;
            end
         end
         ST_LOCKED: begin
            if (accept && bus.in_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_beat && bus.in_last && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= '0;
         drop_cnt_q <= '0;
         last_q     <= '0;
         valid_q    <= '0;
         for (int k = 0; k < NUM_OUT; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
         drop_cnt_q <= drop_cnt_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         for (int k = 0; k < NUM_OUT; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   always_comb begin
      out_data_c = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         out_data_c[k*DATA_W +: DATA_W] = data_q[k];
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out_data   = out_data_c;
   assign bus.out_last   = last_q;
   assign bus.out_valid  = valid_q;
   assign bus.busy       = (state_q == ST_LOCKED);
   assign bus.drop_count = drop_cnt_q;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-NUM_OUT packet demultiplexer with valid/ready handshakes on every port.
- It routes an incoming beat stream to one of NUM_OUT output channels, selected by in_sel on the first beat of each packet.
- The routing is locked for the whole packet.
- Each output channel has a one-entry registered slot, so downstream consumers drain independently of each other.
- Sits downstream of the select-driven mux datapath and fans a shared stream back out to per-consumer channels.

Parameters:
- DATA_W, 8, beat payload width in bits.
- NUM_OUT, 4, number of output channels; legal range 2..2^SEL_W.
- SEL_W, 2, width of in_sel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  input beat payload.
- in_sel  input  SEL_W  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  NUM_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_last  output  NUM_OUT  per-channel last flag.
- out_valid  output  NUM_OUT  per-channel slot full.
- out_ready  input  NUM_OUT  per-channel consumer ready.
- busy  output  1  high while a multi-beat packet is in progress (state LOCKED).
- drop_count  output  8  count of dropped packets; saturating.

Behaviour:
- Reset (asynchronous, immediate on reset=1):
  - out_valid=0, out_data=0, out_last=0.
  - State=IDLE, lock_sel=0, busy=0, drop_count=0.
  - Slot contents are discarded.
- Transfer definitions:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output k transfer: out_valid[k] & out_ready[k].
- target:
  - IDLE: target = in_sel.
  - LOCKED: target = lock_sel; in_sel is ignored.
- in_ready, combinational:
  - target < NUM_OUT: in_ready = ~out_valid[target] | out_ready[target].
  - target >= NUM_OUT: in_ready = 1 (drop path).
  - in_ready must not depend on in_valid.
- Slot k update, per cycle:
  - Input transfer to k: slot loads in_data/in_last, out_valid[k]=1. This also covers the case where the slot is drained in the same cycle (pass-through refill, no bubble).
  - Else, output transfer on k: out_valid[k]=0; out_data/out_last hold their last value.
  - Else: hold.
- Latency: 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 beat/cycle per channel while that out_ready stays high.
- FSM (2 states):
  - IDLE, input transfer with in_last=0 → LOCKED, lock_sel=in_sel.
  - IDLE, input transfer with in_last=1 → stay IDLE (single-beat packet).
  - LOCKED, input transfer with in_last=1 → IDLE.
  - LOCKED, any other case → stay LOCKED.
  - busy = (state == LOCKED).
- Drop path (target >= NUM_OUT):
  - Beats are accepted and discarded; no slot changes.
  - The FSM advances exactly as for a normal packet.
  - drop_count increments by 1 on the last beat of a dropped packet.
  - drop_count saturates at 255, no wrap.
- Independence:
  - A stalled channel (out_ready=0, slot full) stalls the input only while target points at that channel.
  - Other slots continue draining.
- in_valid=0 while LOCKED: state and lock_sel hold indefinitely; no timeout.
- in_sel changing mid-packet has no effect until the cycle after the last-beat transfer.
- Reset mid-packet: FSM returns to IDLE, and the next accepted beat is treated as the first beat of a new packet. Partially delivered packets are not completed.
- out_data/out_last of an empty slot are don't-care for consumers. They must still be the reset value or the last loaded value, never X.

Test Plan:
- Single beat in_sel=2, data=0xA5, last=1, all out_ready=1 → next cycle out_valid=4'b0100, channel 2 data=0xA5, out_last[2]=1; busy stays 0; following cycle out_valid=0.
- 3-beat packet 0x11,0x22,0x33 with in_sel=1 on beat 1, then in_sel=3 on beats 2-3 → all three beats appear on channel 1 on consecutive cycles with last only on 0x33; busy=1 after beat 1 and back to 0 after beat 3.
- Backpressure: out_ready[1]=0, stream 2 beats to channel 1 → first beat is held in the slot, in_ready=0 on the second beat. Raise out_ready[1] → second beat accepted in the same cycle, no loss or duplication. Meanwhile a beat to channel 0 is still accepted when target=0.
- Drop: NUM_OUT=3, packet of 2 beats with in_sel=3 → in_ready=1 both cycles, no out_valid asserted, drop_count 0→1. Drive 300 dropped packets → drop_count stops at 255.
- Full throughput: 16 beats to channel 0 with out_ready[0]=1 continuously → in_ready stays 1 and one output beat every cycle in order, with 1-cycle latency.
- Async reset asserted mid-packet (after beat 2 of 4, slot full), between clock edges → out_valid=0 and busy=0 immediately. After release, the next beat with in_sel=2 routes to channel 2.
